// File: rtl/pipe_delay_elastic_if.sv
// Valid/ready stream bundle for pipe_delay_elastic.
// slave modport: the pipeline (takes in_*, drives out_* and in_ready).
// master modport: the producer/consumer side that surrounds the pipeline.
interface pipe_delay_elastic_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_delay_elastic.sv
// Elastic register pipeline: delays a valid/ready stream by STAGES cycles,
// collapses bubbles under backpressure, supports flush and reports occupancy.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   s      - stream (in_valid/in_ready/in_data, out_valid/out_ready/out_data)
//   flush  - synchronous discard of every held item
//   count  - registered number of valid stages (0..STAGES)
module pipe_delay_elastic #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      STAGES      = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int unsigned     CW          = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   pipe_delay_elastic_if.slave   s,
   input  logic                  flush,
   output logic [CW-1:0]         count
);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] v_nxt;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] load;
   logic [WIDTH-1:0]  d [STAGES];
   logic [CW-1:0]     cnt_nxt;

   // Ready ripples back from the consumer: a stage can take data if it is
   // empty or its own content moves on this cycle.
   always_comb begin : ready_chain
      logic r;
      r   = s.out_ready;
      rdy = '0;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         r      = ~v[i] | r;
         rdy[i] = r;
      end
   end

   // Next-state valid bits, data-load enables and the occupancy they imply.
   always_comb begin : next_state
      load    = '0;
      v_nxt   = v;
      cnt_nxt = '0;
      load[0]  = rdy[0] & s.in_valid & ~flush;
      v_nxt[0] = flush ? 1'b0 : (rdy[0] ? s.in_valid : v[0]);
      for (int i = 1; i < int'(STAGES); i++) begin
         load[i]  = rdy[i] & v[i-1] & ~flush;
         v_nxt[i] = flush ? 1'b0 : (rdy[i] ? v[i-1] : v[i]);
      end
      for (int i = 0; i < int'(STAGES); i++) begin
         cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
      end
   end

   assign s.in_ready  = rdy[0] & ~flush;
   assign s.out_valid = v[STAGES-1];
   assign s.out_data  = d[STAGES-1];

   // Stage registers; data only moves with a valid item and is untouched by flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v     <= '0;
         count <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            d[i] <= RESET_VALUE;
         end
      end else begin
         v     <= v_nxt;
         count <= cnt_nxt;
         if (load[0]) begin
            d[0] <= s.in_data;
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            if (load[i]) begin
               d[i] <= d[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_delay_elastic.sv
// Bench for pipe_delay_elastic: a 3-stage instance and a 1-stage instance,
// each compared cycle by cycle against a slot-position queue model.
module tb_pipe_delay_elastic;

   logic clk = 1'b0;
   logic reset;
   logic flush3, flush1;
   logic [1:0] count3;
   logic [0:0] count1;

   always #5 clk = ~clk;

   pipe_delay_elastic_if #(.WIDTH(8)) i3 ();
   pipe_delay_elastic_if #(.WIDTH(8)) i1 ();

   pipe_delay_elastic #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h3C)) dut3 (
      .clk   (clk),
      .reset (reset),
      .s     (i3),
      .flush (flush3),
      .count (count3)
   );

   pipe_delay_elastic #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .s     (i1),
      .flush (flush1),
      .count (count1)
   );

   // Model: queue of items (oldest first) with their slot position 0..S-1.
   int         cur;
   int         S;
   logic [7:0] rv;
   logic [7:0] md[$];
   int         mp[$];
   logic [7:0] mlast;
   int         total;
   int         bad;

   function automatic logic [31:0] o_ir();
      return (cur == 0) ? 32'(i3.in_ready) : 32'(i1.in_ready);
   endfunction
   function automatic logic [31:0] o_ov();
      return (cur == 0) ? 32'(i3.out_valid) : 32'(i1.out_valid);
   endfunction
   function automatic logic [31:0] o_od();
      return (cur == 0) ? 32'(i3.out_data) : 32'(i1.out_data);
   endfunction
   function automatic logic [31:0] o_cnt();
      return (cur == 0) ? 32'(count3) : 32'(count1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      md.delete();
      mp.delete();
      mlast = rv;
   endtask

   // Lowest free slot bound after this cycle's moves: >0 means slot 0 is free.
   function automatic int free_after(input bit ordy);
      int lim;
      int start;
      lim   = S;
      start = 0;
      if (md.size() > 0 && mp[0] == S - 1 && ordy) start = 1;
      for (int j = start; j < md.size(); j++) begin
         int p;
         p = mp[j];
         if (p + 1 < lim) p = p + 1;
         lim = p;
      end
      return lim;
   endfunction

   task automatic model_edge(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
      int lim;
      lim = S;
      if (md.size() > 0 && mp[0] == S - 1 && ordy) begin
         void'(md.pop_front());
         void'(mp.pop_front());
      end
      if (fl) begin
         md.delete();
         mp.delete();
      end else begin
         for (int j = 0; j < md.size(); j++) begin
            if (mp[j] + 1 < lim) begin
               mp[j] = mp[j] + 1;
               if (mp[j] == S - 1) mlast = md[j];
            end
            lim = mp[j];
         end
         if (iv && lim > 0) begin
            md.push_back(id);
            mp.push_back(0);
            if (S == 1) mlast = id;
         end
      end
   endtask

   // One clock cycle: drive, check in_ready, take the edge, check outputs.
   task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
      bit exp_ir;
      @(negedge clk);
      if (cur == 0) begin
         i3.in_valid = iv; i3.in_data = id; i3.out_ready = ordy; flush3 = fl;
      end else begin
         i1.in_valid = iv; i1.in_data = id; i1.out_ready = ordy; flush1 = fl;
      end
      #1;
      exp_ir = (free_after(ordy) > 0) && !fl;
      chk("in_ready", o_ir(), 32'(exp_ir));
      @(posedge clk);
      model_edge(iv, id, ordy, fl);
      #1;
      chk("out_valid", o_ov(), 32'(md.size() > 0 && mp[0] == S - 1));
      chk("out_data", o_od(), 32'(mlast));
      chk("count", o_cnt(), 32'(md.size()));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cur   = 0;
      S     = 3;
      rv    = 8'h3C;
      reset = 1'b1;
      i3.in_valid = 1'b0; i3.in_data = '0; i3.out_ready = 1'b0; flush3 = 1'b0;
      i1.in_valid = 1'b0; i1.in_data = '0; i1.out_ready = 1'b0; flush1 = 1'b0;
      model_reset();
      #2;
      chk("rst_out_valid", o_ov(), 32'd0);
      chk("rst_out_data", o_od(), 32'h3C);
      chk("rst_count", o_cnt(), 32'd0);
      chk("rst_in_ready", o_ir(), 32'd1);
      chk("rst_out_data_s1", 32'(i1.out_data), 32'h00);
      @(negedge clk);
      reset = 1'b0;

      // Latency: one item, appears after the third edge.
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("lat_count1", o_cnt(), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lat_out_valid", o_ov(), 32'd1);
      chk("lat_out_data", o_od(), 32'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lat_count0", o_cnt(), 32'd0);

      // Streaming 0x00..0x0F.
      for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure with bubble collapsing.
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      chk("bp_full_count", o_cnt(), 32'd3);
      step(1'b1, 8'hA4, 1'b0, 1'b0);
      chk("bp_held_count", o_cnt(), 32'd3);
      step(1'b1, 8'hA4, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush a full pipe while offering 0xFF.
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      step(1'b1, 8'hB3, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("fl_count", o_cnt(), 32'd0);
      chk("fl_out_valid", o_ov(), 32'd0);
      step(1'b1, 8'hC1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset with two items in flight.
      step(1'b1, 8'hD1, 1'b1, 1'b0);
      step(1'b1, 8'hD2, 1'b1, 1'b0);
      @(negedge clk);
      i3.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", o_ov(), 32'd0);
      chk("mid_rst_out_data", o_od(), 32'h3C);
      chk("mid_rst_count", o_cnt(), 32'd0);
      chk("mid_rst_in_ready", o_ir(), 32'd1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic on the 3-stage pipe.
      for (int k = 0; k < 300; k++)
         step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 31) == 0));

      // Switch to the single-stage instance.
      @(negedge clk);
      i3.in_valid = 1'b0; i3.out_ready = 1'b0; flush3 = 1'b0;
      cur = 1;
      S   = 1;
      rv  = 8'h00;
      model_reset();
      for (int k = 0; k < 12; k++) step(1'b1, 8'(8'h10 + k), (k % 2 == 0), 1'b0);
      for (int k = 0; k < 200; k++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_delay_elastic.md
# pipe_delay_elastic

Parametrised elastic register pipeline that delays a WIDTH-bit data stream by STAGES clock cycles under a valid/ready handshake. It replaces fixed single-register delay elements (`q <= #(DELAY) d` style) where the design needs synthesizable cycle delay, backpressure, bubble collapsing, flush and occupancy reporting. It sits between any producer/consumer pair on a valid/ready stream.

## Interface
- WIDTH, 8, data width in bits (≥1)
- STAGES, 2, number of register stages (≥1); unloaded latency in cycles
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every data register on reset
- CW, $clog2(STAGES+1), derived width of `count`; not to be overridden

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- in_valid  input  1  producer has data on in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  input payload
- out_valid  output  1  out_data holds a valid item
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  output payload (last stage register)
- flush  input  1  synchronous discard of all held items
- count  output  CW  number of valid stages, 0..STAGES

## Operation
- State per stage i (0..STAGES-1): valid bit v[i], data register d[i]. Stage 0 is the input, stage STAGES-1 drives out_valid/out_data.
- Ready chain (combinational): rdy[STAGES-1] = !v[STAGES-1] | out_ready; rdy[i] = !v[i] | rdy[i+1].
- in_ready = rdy[0] & !flush.
- On each edge with flush=0, for each stage with rdy[i]=1:
  - stage 0: v[0] <= in_valid; d[0] <= in_data when in_valid.
  - stage i>0: v[i] <= v[i-1]; d[i] <= d[i-1] when v[i-1].
  - Stages with rdy[i]=0 hold.
- Bubble collapsing: an empty stage always accepts from upstream even when downstream is stalled, so a stalled pipeline fills to STAGES items.
- Transfer out: out_valid & out_ready. Transfer in: in_valid & in_ready.
- Order is strictly preserved; no item is dropped or duplicated except by flush/reset.
- flush=1 at an edge: all v[i] <= 0, count <= 0; d[i] unchanged; in_ready=0 that cycle so nothing is accepted. Any out transfer signalled in the flush cycle still counts as consumed by the consumer.
- count: registered popcount of v; updated every edge from the next-state valid bits (not derived from the current ones).
- Reset (async assert, any time including mid-stream): v[i]=0, d[i]=RESET_VALUE, count=0 immediately. Outputs during reset: out_valid=0, out_data=RESET_VALUE, count=0, in_ready=1 (flush=0). Release is synchronous to clk by the integrator.

## Timing
- Latency: item accepted at edge k appears as out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles after its acceptance cycle, with no stalls.
- Throughput: one item per cycle sustained while out_ready=1.
- in_ready depends combinationally on out_ready and v[] (path length STAGES). No other combinational in→out paths; out_valid, out_data and count are registered.
- Full: all v=1 and out_ready=0 → in_ready=0. Full with out_ready=1 → in_ready=1; one in and one out transfer in the same cycle, count unchanged.
- Empty: out_valid=0, count=0, in_ready=1.
- STAGES=1 is a single elastic register: in_ready = !v[0] | out_ready.

## Test plan
- Latency, WIDTH=8, STAGES=3: reset, then in_valid=1, in_data=0x5A for one cycle, out_ready=1 → out_valid=1, out_data=0x5A exactly 3 cycles after acceptance, for one cycle; count goes 1,1,1,0.
- Streaming: push 0x00..0x0F back-to-back, out_ready=1 → outputs 0x00..0x0F on consecutive cycles starting 3 cycles after first accept; in_ready stays 1.
- Backpressure/collapse: out_ready=0, push 0xA1, idle 2 cycles, push 0xA2, 0xA3 → count=3, in_ready=0; 0xA4 held off; raise out_ready → outputs A1,A2,A3,A4 in order, no loss, in_ready=1 in the cycle out_ready rises.
- Flush: fill with 3 items, assert flush with in_valid=1, in_data=0xFF → next cycle count=0, out_valid=0; 0xFF not accepted; next item pushed after flush is the next item output.
- Reset mid-operation: RESET_VALUE=0x3C, 2 items in flight, assert reset between edges → out_valid=0, out_data=0x3C, count=0 immediately; no stale item appears after release.
- STAGES=1: alternating out_ready pattern 1,0,1,0 with continuous input 0x10.. → strict order, count never exceeds 1.
